ecc_secded_pipe: RTL and testbench

ECC_SECDED_PIPE -- requirements
Module: ecc_secded_pipe

---
 rtl/ecc_pkg.sv | 66 ++++++
 rtl/ecc_secded_pipe_if.sv | 33 +++
 rtl/ecc_secded_dec.sv | 39 +++
 rtl/ecc_secded_pipe.sv | 173 +++++++++++++++++
 tb/tb_ecc_secded_pipe.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ecc_pkg.sv
// SECDED check matrix (odd-weight>=3 columns), encoder, parity sizing.
// Shared types: syndrome_t, err_e {NONE, SBIT_DATA, SBIT_PAR, DBIT}.
package ecc_pkg;

  localparam int MAX_D = 248;
  localparam int MAX_P = 10;

  typedef logic [MAX_P-1:0] syndrome_t;

  typedef enum logic [1:0] {
    NONE,
    SBIT_DATA,
    SBIT_PAR,
    DBIT
  } err_e;

  // Data columns are the odd-weight (>=3) codes in ascending order,
  // so any double error yields an even, non-zero syndrome.
  function automatic logic ecc_is_col(input int v);
    int w;
    w = $countones(v);
    return (w >= 3) && w[0];
  endfunction

  function automatic syndrome_t ecc_col(input int k, input int pw);
    syndrome_t c;
    int n;
    c = '0;
    n = 0;
    for (int v = 1; v < (1 << pw); v++) begin
      if (ecc_is_col(v)) begin
        if (n == k) c = syndrome_t'(v);
        n++;
      end
    end
    return c;
  endfunction

  function automatic syndrome_t ecc_encode(
    input logic [MAX_D-1:0] d,
    input int dw,
    input int pw
  );
    syndrome_t p;
    int n;
    p = '0;
    n = 0;
    for (int v = 1; v < (1 << pw); v++) begin
      if (ecc_is_col(v)) begin
        if (n < dw && d[n]) p ^= syndrome_t'(v);
        n++;
      end
    end
    return p;
  endfunction

  function automatic int ecc_par_width(input int dw);
    int p;
    p = 0;
    for (int q = MAX_P; q >= 2; q--) begin
      if ((1 << (q - 1)) >= dw + q) p = q;
    end
    return p;
  endfunction

endpackage

// File: rtl/ecc_secded_pipe_if.sv
// Stream bundle for ecc_secded_pipe: in_* (valid/ready/data/parity/bypass)
// and out_* (valid/ready/data/sbit/dbit/err_pos); master drives in_*.
interface ecc_secded_pipe_if #(
  parameter int DATA_WIDTH   = 52,
  parameter int PARITY_WIDTH = 7
);
  localparam int POS_W = $clog2(DATA_WIDTH + 1);

  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   in_data;
  logic [PARITY_WIDTH-1:0] in_parity;
  logic                    in_bypass;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   out_data;
  logic                    out_sbit_err;
  logic                    out_dbit_err;
  logic [POS_W-1:0]        out_err_pos;

  modport master (
    output in_valid, in_data, in_parity, in_bypass, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_sbit_err, out_dbit_err, out_err_pos
  );

  modport slave (
    input  in_valid, in_data, in_parity, in_bypass, out_ready,
    output in_ready, out_valid, out_data,
    output out_sbit_err, out_dbit_err, out_err_pos
  );

endinterface

// File: rtl/ecc_secded_dec.sv
// Combinational syndrome decode: flip mask, error class, flipped bit index.
// Ports: syndrome in; flip_mask, err_type, err_pos (DATA_WIDTH if none) out.
module ecc_secded_dec
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH   = 52,
  parameter int PARITY_WIDTH = 7,
  localparam int POS_W       = $clog2(DATA_WIDTH + 1)
) (
  input  logic [PARITY_WIDTH-1:0] syndrome,
  output logic [DATA_WIDTH-1:0]   flip_mask,
  output err_e                    err_type,
  output logic [POS_W-1:0]        err_pos
);

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_col
    localparam logic [PARITY_WIDTH-1:0] COL =
      PARITY_WIDTH'(ecc_col(i, PARITY_WIDTH));
    assign flip_mask[i] = (syndrome == COL);
  end

  always_comb begin
    err_pos = POS_W'(DATA_WIDTH);
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (flip_mask[i]) err_pos = POS_W'(i);
    end
  end

  always_comb begin
    err_type = DBIT;
    unique case (1'b1)
      (syndrome == '0):  err_type = NONE;
      (|flip_mask):      err_type = SBIT_DATA;
      $onehot(syndrome): err_type = SBIT_PAR;
      default:           err_type = DBIT;
    endcase
  end

endmodule

// File: rtl/ecc_secded_pipe.sv
// Two-stage SECDED check/correct pipe, write-side encoder, error stats/log.
// Ports: clk, rst_n, bus (slave stream), enc_*, stats/log, clr_stat; ECC_ERR_INJECT_EN adds inj_en/inj_mask.
module ecc_secded_pipe
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH   = 52,
  parameter int PARITY_WIDTH = 7,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ecc_secded_pipe_if.slave        bus,
`ifdef ECC_ERR_INJECT_EN
  input  logic                    inj_en,
  input  logic [DATA_WIDTH+PARITY_WIDTH-1:0] inj_mask,
`endif
  input  logic [DATA_WIDTH-1:0]   enc_data,
  output logic [PARITY_WIDTH-1:0] enc_parity,
  output logic [CNT_WIDTH-1:0]    sbit_cnt,
  output logic [CNT_WIDTH-1:0]    dbit_cnt,
  output logic                    log_valid,
  output logic [PARITY_WIDTH-1:0] log_syndrome,
  output logic                    log_dbit,
  input  logic                    clr_stat
);

  localparam int DW    = DATA_WIDTH;
  localparam int PW    = PARITY_WIDTH;
  localparam int POS_W = $clog2(DW + 1);
  localparam logic [POS_W-1:0] NO_POS = POS_W'(DW);

  if (DW < 8 || DW > MAX_D) begin : g_bad_dw
    $error("DATA_WIDTH out of range 8..248");
  end
  if (PW != ecc_par_width(DW)) begin : g_bad_pw
    $error("PARITY_WIDTH does not match DATA_WIDTH");
  end

  assign enc_parity = PW'(ecc_encode(MAX_D'(enc_data), DW, PW));

  logic [DW-1:0] s0_data;
  logic [PW-1:0] s0_par;
  logic [PW-1:0] s0_syn;

  always_comb begin
    s0_data = bus.in_data;
    s0_par  = bus.in_parity;
`ifdef ECC_ERR_INJECT_EN
    if (inj_en) begin
      s0_data = s0_data ^ inj_mask[DW-1:0];
      s0_par  = s0_par ^ inj_mask[DW+PW-1:DW];
    end
`endif
  end

  assign s0_syn = s0_par ^ PW'(ecc_encode(MAX_D'(s0_data), DW, PW));

  logic             advance;
  logic             s1_valid;
  logic [DW-1:0]    s1_data;
  logic [PW-1:0]    s1_syn;
  logic             s1_bypass;
  logic             o_valid;
  logic [DW-1:0]    o_data;
  logic             o_sbit;
  logic             o_dbit;
  logic [POS_W-1:0] o_pos;
  logic [PW-1:0]    o_syn;

  // Whole pipe moves together; an empty output slot lets it move too.
  assign advance      = bus.out_ready | ~o_valid;
  assign bus.in_ready = advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_syn    <= '0;
      s1_bypass <= 1'b0;
    end else if (advance) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_data   <= s0_data;
        s1_syn    <= s0_syn;
        s1_bypass <= bus.in_bypass;
      end
    end
  end

  logic [DW-1:0]    dec_mask;
  err_e             dec_err;
  logic [POS_W-1:0] dec_pos;

  ecc_secded_dec #(
    .DATA_WIDTH   (DW),
    .PARITY_WIDTH (PW)
  ) u_dec (
    .syndrome  (s1_syn),
    .flip_mask (dec_mask),
    .err_type  (dec_err),
    .err_pos   (dec_pos)
  );

  logic [DW-1:0]    n_data;
  logic             n_sbit;
  logic             n_dbit;
  logic [POS_W-1:0] n_pos;

  always_comb begin
    n_data = s1_data ^ dec_mask;
    n_sbit = (dec_err == SBIT_DATA) || (dec_err == SBIT_PAR);
    n_dbit = (dec_err == DBIT);
    n_pos  = dec_pos;
    if (s1_bypass) begin
      n_data = s1_data;
      n_sbit = 1'b0;
      n_dbit = 1'b0;
      n_pos  = NO_POS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_sbit  <= 1'b0;
      o_dbit  <= 1'b0;
      o_pos   <= NO_POS;
      o_syn   <= '0;
    end else if (advance) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_data <= n_data;
        o_sbit <= n_sbit;
        o_dbit <= n_dbit;
        o_pos  <= n_pos;
        o_syn  <= s1_syn;
      end
    end
  end

  assign bus.out_valid    = o_valid;
  assign bus.out_data     = o_data;
  assign bus.out_sbit_err = o_sbit;
  assign bus.out_dbit_err = o_dbit;
  assign bus.out_err_pos  = o_pos;

  logic xfer_err;
  assign xfer_err = o_valid & bus.out_ready & (o_sbit | o_dbit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbit_cnt     <= '0;
      dbit_cnt     <= '0;
      log_valid    <= 1'b0;
      log_syndrome <= '0;
      log_dbit     <= 1'b0;
    end else if (clr_stat) begin
      sbit_cnt  <= '0;
      dbit_cnt  <= '0;
      log_valid <= 1'b0;
    end else if (xfer_err) begin
      if (o_sbit && sbit_cnt != '1) sbit_cnt <= sbit_cnt + CNT_WIDTH'(1);
      if (o_dbit && dbit_cnt != '1) dbit_cnt <= dbit_cnt + CNT_WIDTH'(1);
      if (!log_valid) begin
        log_valid    <= 1'b1;
        log_syndrome <= o_syn;
        log_dbit     <= o_dbit;
      end
    end
  end

endmodule

// File: tb/tb_ecc_secded_pipe.sv
// Directed bench for ecc_secded_pipe: encode, correct, stall, stats, reset.
// Expected parities are hand-computed from the odd-weight column order.
module tb_ecc_secded_pipe;

  localparam int DW = 52;
  localparam int PW = 7;
  localparam int CW = 4;
  localparam int POS_W = $clog2(DW + 1);

  localparam logic [DW-1:0] D0  = 52'h0_1234_5678_9ABC;
  localparam logic [PW-1:0] P0  = 7'h0F;
  localparam logic [DW-1:0] B17 = 52'h0_0000_0002_0000;
  localparam logic [DW-1:0] B3  = 52'h0_0000_0000_0008;
  localparam logic [DW-1:0] B40 = 52'h0_0100_0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DW-1:0] enc_data;
  logic [PW-1:0] enc_parity;
  logic [CW-1:0] sbit_cnt;
  logic [CW-1:0] dbit_cnt;
  logic log_valid;
  logic [PW-1:0] log_syndrome;
  logic log_dbit;
  logic clr_stat;

  int tests = 0;
  int failed = 0;

  logic [DW-1:0] bd [4] = '{52'd1, 52'd2, 52'd4, 52'd8};
  logic [PW-1:0] bp [4] = '{7'd7, 7'd11, 7'd13, 7'd14};
  logic [DW-1:0] rx [$];

  ecc_secded_pipe_if #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW)) bus ();

  ecc_secded_pipe #(
    .DATA_WIDTH   (DW),
    .PARITY_WIDTH (PW),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .enc_data     (enc_data),
    .enc_parity   (enc_parity),
    .sbit_cnt     (sbit_cnt),
    .dbit_cnt     (dbit_cnt),
    .log_valid    (log_valid),
    .log_syndrome (log_syndrome),
    .log_dbit     (log_dbit),
    .clr_stat     (clr_stat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [PW-1:0] p,
                      input logic byp);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_parity = p;
    bus.in_bypass = byp;
    tick();
    bus.in_valid = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int sent;
    int got;
    int emitted;
    logic acc;
    logic dropped;
    logic held_bad;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_parity = '0;
    bus.in_bypass = 1'b0;
    bus.out_ready = 1'b1;
    enc_data      = '0;
    clr_stat      = 1'b0;

    #12;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_err_pos", bus.out_err_pos, DW);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_sbit_cnt", sbit_cnt, 0);
    chk("rst_log_valid", log_valid, 0);
    rst_n = 1'b1;
    tick();

    enc_data = D0;
    #1;
    chk("enc_d0", enc_parity, P0);
    enc_data = B17;
    #1;
    chk("enc_b17", enc_parity, 7'h2F);
    enc_data = 52'd1;
    #1;
    chk("enc_b0", enc_parity, 7'h07);
    enc_data = '0;
    #1;
    chk("enc_zero", enc_parity, 0);

    bus.in_valid  = 1'b1;
    bus.in_data   = D0;
    bus.in_parity = P0;
    bus.in_bypass = 1'b0;
    tick();
    chk("lat1_valid", bus.out_valid, 0);
    bus.in_valid = 1'b0;
    tick();
    chk("clean_valid", bus.out_valid, 1);
    chk("clean_data", bus.out_data, D0);
    chk("clean_sbit", bus.out_sbit_err, 0);
    chk("clean_dbit", bus.out_dbit_err, 0);
    chk("clean_pos", bus.out_err_pos, DW);
    tick();
    chk("clean_drain", bus.out_valid, 0);
    chk("clean_scnt", sbit_cnt, 0);
    chk("clean_dcnt", dbit_cnt, 0);
    chk("clean_log", log_valid, 0);

    send(D0 ^ B17, P0, 1'b0);
    chk("s17_data", bus.out_data, D0);
    chk("s17_sbit", bus.out_sbit_err, 1);
    chk("s17_dbit", bus.out_dbit_err, 0);
    chk("s17_pos", bus.out_err_pos, 17);
    tick();
    chk("s17_scnt", sbit_cnt, 1);
    chk("s17_logv", log_valid, 1);
    chk("s17_logd", log_dbit, 0);
    chk("s17_logs", log_syndrome, 7'h2F);

    send(D0 ^ B3 ^ B40, P0, 1'b0);
    chk("d_data", bus.out_data, D0 ^ B3 ^ B40);
    chk("d_dbit", bus.out_dbit_err, 1);
    chk("d_sbit", bus.out_sbit_err, 0);
    chk("d_pos", bus.out_err_pos, DW);
    tick();
    chk("d_dcnt", dbit_cnt, 1);
    chk("d_logs", log_syndrome, 7'h2F);
    chk("d_logd", log_dbit, 0);

    send(D0, P0 ^ 7'h01, 1'b0);
    chk("p_data", bus.out_data, D0);
    chk("p_sbit", bus.out_sbit_err, 1);
    chk("p_pos", bus.out_err_pos, DW);
    tick();
    chk("p_scnt", sbit_cnt, 2);
    chk("p_logs", log_syndrome, 7'h2F);

    send(D0 ^ B17, P0, 1'b1);
    chk("byp_data", bus.out_data, D0 ^ B17);
    chk("byp_sbit", bus.out_sbit_err, 0);
    chk("byp_pos", bus.out_err_pos, DW);
    tick();
    chk("byp_scnt", sbit_cnt, 2);

    sent = 0;
    got = 0;
    dropped = 1'b0;
    held_bad = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      bus.out_ready = (cyc >= 5);
      bus.in_valid  = (sent < 4);
      bus.in_bypass = 1'b0;
      if (sent < 4) begin
        bus.in_data   = bd[sent];
        bus.in_parity = bp[sent];
      end
      #1;
      acc = bus.in_valid && bus.in_ready;
      if (bus.in_valid && !bus.in_ready) dropped = 1'b1;
      if (bus.out_valid && !bus.out_ready && bus.out_data !== bd[0])
        held_bad = 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        rx.push_back(bus.out_data);
        got++;
      end
      tick();
      if (acc) sent++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("stall_count", got, 4);
    chk("stall_drop", dropped, 1);
    chk("stall_hold", held_bad, 0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("stall_beat%0d", i), (i < rx.size()) ? rx[i] : '1, bd[i]);
    tick();
    chk("stall_empty", bus.out_valid, 0);

    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    chk("clr_scnt", sbit_cnt, 0);
    chk("clr_dcnt", dbit_cnt, 0);
    chk("clr_logv", log_valid, 0);

    for (int i = 0; i < 15; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_data   = 52'd1;
      bus.in_parity = 7'd0;
      bus.in_bypass = 1'b0;
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("burst_scnt", sbit_cnt, 15);
    chk("burst_logs", log_syndrome, 7'h07);
    send(52'd1, 7'd0, 1'b0);
    chk("sat_data", bus.out_data, 0);
    tick();
    chk("sat_scnt", sbit_cnt, 15);

    send(52'd1, 7'd0, 1'b0);
    chk("cc_valid", bus.out_valid, 1);
    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    chk("cc_scnt", sbit_cnt, 0);
    chk("cc_logv", log_valid, 0);
    send(D0, P0 ^ 7'h40, 1'b0);
    tick();
    chk("relog_scnt", sbit_cnt, 1);
    chk("relog_logv", log_valid, 1);
    chk("relog_logs", log_syndrome, 7'h40);

    bus.in_valid  = 1'b1;
    bus.in_data   = 52'd1;
    bus.in_parity = 7'd7;
    tick();
    bus.in_data   = 52'd2;
    bus.in_parity = 7'd11;
    tick();
    bus.in_valid = 1'b0;
    chk("inflight_valid", bus.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_ready", bus.in_ready, 1);
    chk("arst_pos", bus.out_err_pos, DW);
    chk("arst_data", bus.out_data, 0);
    chk("arst_scnt", sbit_cnt, 0);
    chk("arst_logv", log_valid, 0);
    #2;
    rst_n = 1'b1;
    emitted = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.out_valid) emitted++;
    end
    chk("arst_no_emit", emitted, 0);
    send(52'd8, 7'd14, 1'b0);
    chk("post_rst_data", bus.out_data, 8);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
